// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch sequencer.
// States, default widths and the zero-to-one clamp used on latched config values.
package glitch_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NPW   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // Pulse width, gap and pulse count of zero behave as one.
    function automatic logic [31:0] clamp_zero_to_one(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Control/status bundle between the glitch sequencer and its host.
// The master drives arm/abort/trigger/config and observes the glitch status outputs.
interface glitch_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int NPW   = 8
);
    logic             arm;
    logic             abort;
    logic             trigger;
    logic [WIDTH-1:0] delay;
    logic [WIDTH-1:0] pulse_width;
    logic [WIDTH-1:0] gap;
    logic [NPW-1:0]   num_pulses;
    logic             glitch_out;
    logic             armed;
    logic             busy;
    logic             done;

    modport master (
        output arm, abort, trigger, delay, pulse_width, gap, num_pulses,
        input  glitch_out, armed, busy, done
    );

    modport slave (
        input  arm, abort, trigger, delay, pulse_width, gap, num_pulses,
        output glitch_out, armed, busy, done
    );
endinterface

// File: rtl/glitch_sequencer_up_counter.sv
// Saturating up-counter shared by the delay, pulse and gap intervals.
// Clear wins over enable; the count holds at all-ones instead of wrapping.
module up_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/glitch_sequencer.sv
// Glitch timing core: arm, wait for a trigger rising edge, count a delay, emit a pulse train.
// Define GLITCH_SEQ_TRIG_SYNC_EN to pass trigger through a 2-flop synchronizer (+2 cycles latency).
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NPW   = DEF_NPW
) (
    input logic               clk,
    input logic               rst_n,
    glitch_sequencer_if.slave bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_delay_lat;
    logic [WIDTH-1:0] r_pw_lat;
    logic [WIDTH-1:0] r_gap_lat;
    logic [NPW-1:0]   r_pulses_rem;
    logic             r_trig_prev;
    logic             w_trig;
    logic             w_trig_edge;
    logic             w_latch_cfg;
    logic             w_dec_pulses;
    logic             w_interval_end;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [WIDTH-1:0] w_count;
    logic             r_glitch_out;
    logic             r_armed;
    logic             r_busy;
    logic             r_done;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.trigger;
            r_sync2 <= r_sync1;
        end
    end

    assign w_trig = r_sync2;
`else
    assign w_trig = bus.trigger;
`endif

    // History tracks in every state so a trigger already high at arm never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trig_prev <= 1'b0;
        else        r_trig_prev <= w_trig;
    end

    assign w_trig_edge = w_trig & ~r_trig_prev;

    always_comb begin
        unique case (r_state)
            S_DELAY: w_interval_end = (w_count == r_delay_lat - 1'b1);
            S_PULSE: w_interval_end = (w_count == r_pw_lat - 1'b1);
            S_GAP:   w_interval_end = (w_count == r_gap_lat - 1'b1);
            default: w_interval_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_latch_cfg  = 1'b0;
        w_dec_pulses = 1'b0;
        if (bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        w_state_next = S_ARMED;
                        w_latch_cfg  = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_trig_edge) begin
                        w_state_next = (r_delay_lat == '0) ? S_PULSE : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (w_interval_end) w_state_next = S_PULSE;
                end
                S_PULSE: begin
                    if (w_interval_end) begin
                        if (r_pulses_rem > NPW'(1)) begin
                            w_state_next = S_GAP;
                            w_dec_pulses = 1'b1;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    if (w_interval_end) w_state_next = S_PULSE;
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: config registers are reset too; armed compares must never see X after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay_lat  <= '0;
            r_pw_lat     <= '0;
            r_gap_lat    <= '0;
            r_pulses_rem <= '0;
        end else if (w_latch_cfg) begin
            r_delay_lat  <= bus.delay;
            r_pw_lat     <= WIDTH'(clamp_zero_to_one(32'(bus.pulse_width)));
            r_gap_lat    <= WIDTH'(clamp_zero_to_one(32'(bus.gap)));
            r_pulses_rem <= NPW'(clamp_zero_to_one(32'(bus.num_pulses)));
        end else if (w_dec_pulses) begin
            r_pulses_rem <= r_pulses_rem - 1'b1;
        end
    end

    // Any state change starts a fresh interval at count zero.
    assign w_cnt_clr = (w_state_next != r_state);
    assign w_cnt_en  = (r_state == S_DELAY) || (r_state == S_PULSE) || (r_state == S_GAP);

    up_counter #(.WIDTH(WIDTH)) u_interval_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // Outputs follow the state one cycle later; abort forces them low on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_out <= 1'b0;
            r_armed      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_glitch_out <= (r_state == S_PULSE) && !bus.abort;
            r_armed      <= (r_state == S_ARMED) && !bus.abort;
            r_busy       <= w_cnt_en && !bus.abort;
            r_done       <= (r_state == S_DONE) && !bus.abort;
        end
    end

    assign bus.glitch_out = r_glitch_out;
    assign bus.armed      = r_armed;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: stimulus pushes expected glitch edges and done strobes,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_glitch_sequencer;
    import glitch_pkg::*;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 0;
`endif

    typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_en = 1'b0;
    logic prev_g = 1'b0;
    ev_t  sb[$];

    glitch_sequencer_if #(.WIDTH(16), .NPW(8)) bus ();

    glitch_sequencer #(.WIDTH(16), .NPW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic see_event(input ev_kind_t k, input int c);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, c);
        end else begin
            e = sb.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            check("event_cycle", 64'(c), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.glitch_out !== prev_g) see_event(bus.glitch_out ? EV_RISE : EV_FALL, cyc);
            if (bus.done === 1'b1)         see_event(EV_DONE, cyc);
        end
        prev_g = bus.glitch_out;
    end

    function automatic int clamp1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // t is the cycle whose edge samples the (conditioned) trigger rising edge.
    task automatic push_shot(input int t, input int d, input int pw, input int g, input int n);
        int p  = clamp1(pw);
        int gg = clamp1(g);
        int nn = clamp1(n);
        for (int k = 0; k < nn; k++) begin
            sb.push_back('{EV_RISE, t + 1 + d + k * (p + gg)});
            sb.push_back('{EV_FALL, t + 1 + d + k * (p + gg) + p});
        end
        sb.push_back('{EV_DONE, t + 1 + d + nn * p + (nn - 1) * gg});
    endtask

    // Config inputs are scrambled after arm to show they were latched.
    task automatic arm_cfg(input logic [15:0] d, input logic [15:0] pw, input logic [15:0] g,
                           input logic [7:0] n);
        @(negedge clk);
        bus.delay = d; bus.pulse_width = pw; bus.gap = g; bus.num_pulses = n;
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.delay = 16'd40; bus.pulse_width = 16'd9; bus.gap = 16'd7; bus.num_pulses = 8'd5;
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain_timeout_pending", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_armed", bus.armed, 1'b0);
    endtask

    task automatic run_shot(input int d, input int pw, input int g, input int n);
        int c0;
        arm_cfg(16'(d), 16'(pw), 16'(g), 8'(n));
        @(negedge clk);
        check("armed_high", bus.armed, 1'b1);
        bus.trigger = 1'b1;
        c0 = cyc;
        push_shot(c0 + 1 + LAT_EXTRA, d, pw, g, n);
        @(negedge clk);
        bus.trigger = 1'b0;
        wait_drain(d + clamp1(n) * (clamp1(pw) + clamp1(g)) + 20);
    endtask

    initial begin
        int c0;
        int r;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0;
        bus.delay = '0; bus.pulse_width = '0; bus.gap = '0; bus.num_pulses = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_glitch", bus.glitch_out, 1'b0);
        check("rst_armed", bus.armed, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n  = 1'b1;
        prev_g = bus.glitch_out;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_armed", bus.armed, 1'b0);
        check("post_rst_busy", bus.busy, 1'b0);

        // Single pulse after a delay, then three 1-cycle pulses with 2-cycle gaps
        run_shot(5, 3, 0, 1);
        run_shot(0, 0, 2, 3);

        // Trigger already high at arm must not fire; later edge fires; retrigger mid-delay ignored
        bus.trigger = 1'b1;
        repeat (2) @(negedge clk);
        arm_cfg(16'd6, 16'd2, 16'd1, 8'd1);
        repeat (4) @(negedge clk);
        check("held_trig_armed", bus.armed, 1'b1);
        check("held_trig_busy", bus.busy, 1'b0);
        bus.trigger = 1'b0;
        @(negedge clk);
        bus.trigger = 1'b1;
        c0 = cyc;
        push_shot(c0 + 1 + LAT_EXTRA, 6, 2, 1, 1);
        @(negedge clk); bus.trigger = 1'b0;
        @(negedge clk); bus.trigger = 1'b1;
        @(negedge clk); bus.trigger = 1'b0;
        wait_drain(40);
        @(negedge clk); bus.trigger = 1'b1;
        @(negedge clk); bus.trigger = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_trig_busy", bus.busy, 1'b0);

        // Abort in the second cycle of a long pulse
        arm_cfg(16'd2, 16'd10, 16'd1, 8'd1);
        @(negedge clk);
        bus.trigger = 1'b1;
        c0 = cyc;
        r  = c0 + 1 + LAT_EXTRA + 1 + 2;
        sb.push_back('{EV_RISE, r});
        sb.push_back('{EV_FALL, r + 1});
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (r - (c0 + 1)) @(negedge clk);
        check("abort_pre_glitch", bus.glitch_out, 1'b1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_glitch", bus.glitch_out, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        wait_drain(20);

        // Arm together with abort stays idle
        @(negedge clk);
        bus.arm = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("arm_abort_armed", bus.armed, 1'b0);
        bus.trigger = 1'b1;
        @(negedge clk); bus.trigger = 1'b0;
        repeat (4) @(negedge clk);
        check("arm_abort_busy", bus.busy, 1'b0);

        // Maximum delay without wrap, then async reset mid-pulse
        arm_cfg(16'hFFFF, 16'd4, 16'd1, 8'd1);
        @(negedge clk);
        bus.trigger = 1'b1;
        c0 = cyc;
        r  = c0 + 1 + LAT_EXTRA + 1 + 65535;
        sb.push_back('{EV_RISE, r});
        sb.push_back('{EV_FALL, r + 1});
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (r + 1 - (c0 + 1)) @(posedge clk);
        #1;
        check("maxdly_glitch_high", bus.glitch_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_glitch", bus.glitch_out, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Timing core of the glitch path: waits for an armed trigger edge, counts a programmable delay, then drives a programmed train of glitch pulses.
- Sits downstream of the trigger input conditioning and upstream of the glitch output driver (crowbar/clock-mux select).
- All interval timing uses saturating up_counter instances; this block owns sequencing and the compare logic.

Parameters:
- WIDTH, 16, bit width of the delay, pulse-width and gap values and of their counters.
- NPW, 8, bit width of the pulse-count value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  level; sampled in IDLE, latches config and enters ARMED.
- abort  in  1  level; returns to IDLE from any state.
- trigger  in  1  target trigger (rising edge is the event).
- delay  in  WIDTH  cycles from trigger edge to first pulse.
- pulse_width  in  WIDTH  high cycles per pulse; 0 treated as 1.
- gap  in  WIDTH  low cycles between pulses; 0 treated as 1.
- num_pulses  in  NPW  pulses per shot; 0 treated as 1.
- glitch_out  out  1  registered glitch enable.
- armed  out  1  high in ARMED.
- busy  out  1  high in DELAY, PULSE, GAP.
- done  out  1  one-cycle strobe at shot completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE, glitch_out=0, armed=0, busy=0, done=0, counters cleared, trigger history=0.
- Outputs are registered from state; no combinational input-to-output path.
- Config (delay, pulse_width, gap, num_pulses) is latched on the IDLE->ARMED transition. Input changes after that have no effect until the next arm.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE.
- IDLE: when arm=1 and abort=0, go to ARMED.
- ARMED: a rising edge is trigger=1 with the previous sample 0. The previous-sample register updates in every state, so a trigger already high at arm does not fire.
  - On edge with delay_lat>0, go to DELAY.
  - On edge with delay_lat=0, go to PULSE.
- Latency: if the trigger edge is sampled at clock edge T, glitch_out goes high at edge T+1+delay_lat.
- DELAY: counter enabled. Go to PULSE when count==delay_lat-1.
- PULSE: glitch_out=1 for exactly max(pulse_width,1) cycles.
  - Then go to GAP if pulses_remaining>1, else DONE.
  - pulses_remaining starts at max(num_pulses,1) and decrements at each pulse end.
- GAP: glitch_out=0 for exactly max(gap,1) cycles, then go to PULSE.
- DONE: done=1 for one cycle, glitch_out=0, then go to IDLE.
- Counters: each interval counter is cleared (clr) on interval entry. Counters saturate at all-ones and never wrap; max delay is 2^WIDTH-1.
- abort: highest priority.
  - Next state is IDLE from any state, and glitch_out=0 on the next edge.
  - done is not pulsed.
  - abort and arm in the same cycle resolves to IDLE.
- arm outside IDLE is ignored. Trigger edges outside ARMED are ignored, including retriggers during a shot.
- rst_n asserted mid-pulse clears glitch_out immediately (asynchronously).

Optional Feature:
- Macro GLITCH_SEQ_TRIG_SYNC_EN.
  - Defined: trigger passes through a 2-flop synchronizer before edge detection. Trigger-to-glitch latency becomes delay_lat+3 cycles. Synchronizer flops reset to 0.
  - Undefined: trigger is used directly (must already be synchronous to clk). Latency is delay_lat+1.

Decomposition:
- Shared package glitch_pkg:
  - state enum (IDLE, ARMED, DELAY, PULSE, GAP, DONE);
  - default WIDTH/NPW constants;
  - helper function clamp-zero-to-one.
- Sub-module: up_counter (existing), one instance for delay/pulse/gap intervals sharing a single counter, WIDTH=WIDTH. A second instance or an internal down-counter handles pulses_remaining.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, state IDLE; release rst_n -> no activity.
- delay=5, pulse_width=3, num_pulses=1, arm, trigger edge at cycle T -> glitch_out high at T+6..T+8, done at T+9, then IDLE.
- delay=0, pulse_width=0, gap=2, num_pulses=3 -> three 1-cycle pulses, first at T+1, each separated by 2 low cycles; single done after the last.
- trigger held high before arm -> no shot; trigger low then high -> shot fires; second edge mid-DELAY -> ignored (one shot only).
- abort asserted during PULSE cycle 2 of pulse_width=10 -> glitch_out 0 next cycle, IDLE, done stays 0; arm with abort=1 -> stays IDLE.
- delay=16'hFFFF -> glitch_out rises exactly 65536 cycles after the edge (no wrap); rst_n low mid-pulse -> glitch_out drops without waiting for clk.
